// File: rtl/vga_board_writer_if.sv
// Request channel from game logic and RAM write port of the snake board writer.
interface vga_board_writer_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned XW = 5,
  parameter int unsigned YW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic [XW-1:0] req_x;
  logic [YW-1:0] req_y;
  logic [DW-1:0] req_data;

  logic             we;
  logic [XW+YW-1:0] waddr;
  logic [DW-1:0]    wdata;

  modport master (
    output req_valid, req_x, req_y, req_data,
    input  req_ready, we, waddr, wdata
  );

  modport slave (
    input  req_valid, req_x, req_y, req_data,
    output req_ready, we, waddr, wdata
  );
endinterface

// File: rtl/vga_board_writer.sv
// Write side of the snake board RAM: buffers cell updates in a 4-deep FIFO and
// commits them, or a full-board clear sweep, only while the display is in vblank.
module vga_board_writer #(
  parameter int unsigned    XBLOCKS    = 32,
  parameter int unsigned    YBLOCKS    = 24,
  parameter int unsigned    DW         = 4,
  parameter logic [DW-1:0]  CLEAR_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              clear_req,
  vga_board_writer_if.slave bus,
  output logic              busy,
  output logic              range_err
);

  localparam int unsigned XW    = 5;
  localparam int unsigned YW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [XW-1:0] cx, cx_n;
  logic [YW-1:0] cy, cy_n;

  entry_t        fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  entry_t        head;

  logic             accept, in_range, push, pop;
  logic             we_n;
  logic [XW+YW-1:0] waddr_n;
  logic [DW-1:0]    wdata_n;

  // Request handshake and range filtering; out-of-range rows are dropped.
  assign bus.req_ready = (count < CW'(DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;
  assign in_range      = (bus.req_y < YW'(YBLOCKS));
  assign push          = accept & in_range;
  assign head          = fifo_mem[rd_ptr];
  assign busy          = (state == S_CLEAR) || (count != '0);

  // State, sweep counters and the RAM write register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_CLEAR;
      cx        <= '0;
      cy        <= '0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      range_err <= 1'b0;
    end else begin
      state     <= state_n;
      cx        <= cx_n;
      cy        <= cy_n;
      bus.we    <= we_n;
      bus.waddr <= waddr_n;
      bus.wdata <= wdata_n;
      range_err <= accept & ~in_range;
    end
  end

  // Next state, sweep advance and write selection; clear_req beats a pop.
  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    pop     = 1'b0;
    we_n    = 1'b0;
    waddr_n = bus.waddr;
    wdata_n = bus.wdata;
    unique case (state)
      S_CLEAR: begin
        if (vblank) begin
          we_n    = 1'b1;
          waddr_n = {cx, cy};
          wdata_n = CLEAR_DATA;
          if (cx == XW'(XBLOCKS - 1)) begin
            cx_n = '0;
            if (cy == YW'(YBLOCKS - 1)) begin
              cy_n    = '0;
              state_n = S_IDLE;
            end else begin
              cy_n = cy + YW'(1);
            end
          end else begin
            cx_n = cx + XW'(1);
          end
        end
      end
      S_IDLE: begin
        if (clear_req) begin
          state_n = S_CLEAR;
        end else if ((count != '0) && vblank) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (clear_req) begin
          state_n = S_CLEAR;
        end else if ((count == '0) || !vblank) begin
          state_n = S_IDLE;
        end else begin
          pop     = 1'b1;
          we_n    = 1'b1;
          waddr_n = {head.x, head.y};
          wdata_n = head.data;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{x: bus.req_x, y: bus.req_y, data: bus.req_data};
    end
  end

endmodule

// File: doc/vga_board_writer.md
# vga_board_writer

Write-side port of the snake board memory that `vga_controller` reads: it accepts cell-update requests from game logic, buffers them in a 4-entry FIFO, and commits them into the 32×24 block RAM only during vertical blanking so a frame is never torn. It also performs a full-board clear sweep after reset and on request. The write address uses the same `{hblock, vblock}` packing as the controller's `raddr`, so both ends index the RAM identically.

## Interface
- `XBLOCKS`, 32: horizontal cells per row (640/20).
- `YBLOCKS`, 24: vertical cells (480/20).
- `DW`, 4: cell data width.
- `CLEAR_DATA`, 0: value written by a clear sweep.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `vblank`  in  1  high while the controller is in vertical porch; writes are committed only while high.
- `req_valid`  in  1  game logic presents a cell update.
- `req_ready`  out  1  block can take a request this cycle (`fifo_count < 4`); combinational.
- `req_x`  in  5  horizontal cell index.
- `req_y`  in  5  vertical cell index.
- `req_data`  in  DW  cell value.
- `clear_req`  in  1  single-cycle pulse that starts a clear sweep.
- `we`  out  1  RAM write enable (registered).
- `waddr`  out  10  `{x, y}` RAM address (registered).
- `wdata`  out  DW  RAM write data (registered).
- `busy`  out  1  high in CLEAR or while the FIFO is non-empty.
- `range_err`  out  1  one-cycle pulse: an accepted request had `req_y >= YBLOCKS`.

## Operation
- Handshake: a transfer occurs at a posedge where `req_valid & req_ready`. If `req_y < YBLOCKS`, `{req_x, req_y, req_data}` is pushed. Otherwise the request is dropped and `range_err` pulses the next cycle. `req_x` is always in range.
- FIFO: depth 4, with a 3-bit count. A push and a pop may occur in the same cycle. No push is possible when count is 4 because `req_ready` is low.
- States:
  - CLEAR: the sweep counters `cx` (0..31, inner) and `cy` (0..23, outer) advance one cell per cycle while `vblank` is high and hold while it is low. Each advancing cycle writes `CLEAR_DATA` to `{cx,cy}`. After writing `{31,23}` the state goes to IDLE and the counters return to 0. The FIFO is not drained, but it still accepts pushes.
  - IDLE: if `clear_req` is high, go to CLEAR. Otherwise, if the FIFO is non-empty and `vblank` is high, go to DRAIN.
  - DRAIN: each cycle with `vblank` high and the FIFO non-empty pops the head and writes it. If `clear_req` is high, go to CLEAR; no pop occurs that cycle. If the FIFO is empty or `vblank` is low, go to IDLE.
- `clear_req` arriving while already in CLEAR is ignored and does not restart the sweep.
- `clear_req` has priority over a pending pop in the same cycle.
- When `we` is low, `waddr` and `wdata` hold their last values.

## Timing
- Reset (asserted, low): state CLEAR, `cx=cy=0`, FIFO empty, `we=0`, `waddr=0`, `wdata=0`, `range_err=0`. `busy=1` and `req_ready=1`.
- Reset release mid-sweep or mid-drain: the sweep restarts from `{0,0}` and all FIFO contents are discarded.
- Accept-to-write latency with an empty FIFO, IDLE state, and `vblank` high: the request is accepted at edge k, the state moves to DRAIN at edge k+1, and `we=1` with the data follows edge k+2.
- From DRAIN, throughput is one write per cycle.
- `vblank` falling: a write already registered completes. No new `we` is asserted from the edge that samples `vblank=0` onward.
- Full sweep duration: 768 cycles of `vblank` high. The controller's 45 porch lines × 800 = 36000 cycles easily cover it within one blanking interval.
- `busy` is combinational from state and FIFO count. It drops in the cycle after the last FIFO pop, or after the last clear write when the FIFO is empty.

## Test plan
- Reset with `vblank=1`: expect exactly 768 `we` pulses, the first at `waddr=0` and the last at `waddr={5'd31,5'd23}`, all with `wdata=0`. `busy` falls afterwards.
- After the clear, one request `x=5, y=7, data=4'hA` with `vblank=1`: `we` appears 2 cycles after acceptance with `waddr=10'b00101_00111` and `wdata=A`.
- With `vblank=0`, push 5 requests back-to-back: `req_ready` falls after the 4th. Raise `vblank`: 4 consecutive writes in FIFO order, then the 5th is accepted and written.
- Request `y=24`: the handshake completes, `range_err` pulses once, and no `we` results.
- `clear_req` during DRAIN with 2 entries queued: a full sweep occurs first, then both entries are written, and they are not overwritten by the clear.
- Assert `reset` low during a sweep at cell 100: outputs return to reset values immediately, and after release the sweep restarts at `waddr=0`.
